sdram_frame_arbiter: RTL and testbench

- Parametrised successor of the single-frame SDRAM read/write sequencer. Arbitrates burst-granular SDRAM access between the camera image writer and the VGA reader over a ring of NUM_BUFS frame buffers.
- Generates the burst start address, plus write_en and read_en, towards the SDRAM burst engine.
- Tracks completed-but-unread frames, so the reader only ever sees whole frames and the writer never overwrites an unread frame.
- Sits between the capture/VGA FIFOs and the SDRAM command controller.

---
 rtl/sdram_frame_arbiter.sv | 171 +++++++++++++++++
 tb/tb_sdram_frame_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_frame_arbiter.sv
// Burst-granular SDRAM arbiter between the camera writer and the VGA reader
// over a ring of NUM_BUFS frame buffers, tracking completed-but-unread frames.
module sdram_frame_arbiter #(
  parameter int unsigned ADDR_W           = 20,
  parameter int unsigned BASE_ADDR        = 0,
  parameter int unsigned BURST_LEN        = 8,
  parameter int unsigned BURSTS_PER_FRAME = 30,
  parameter int unsigned FRAME_STRIDE     = 256,
  parameter int unsigned NUM_BUFS         = 2
) (
  input  logic                            S_CLK,
  input  logic                            RST,
  input  logic                            image_wr_req,
  input  logic                            vga_rd_req,
  input  logic                            write_ack,
  input  logic                            read_ack,
  output logic [ADDR_W-1:0]               addr,
  output logic                            write_en,
  output logic                            read_en,
  output logic                            wr_frame_done,
  output logic                            rd_frame_done,
  output logic                            rd_underrun,
  output logic [$clog2(NUM_BUFS+1)-1:0]   frames_ready,
  output logic [$clog2(NUM_BUFS)-1:0]     wr_buf_idx,
  output logic [$clog2(NUM_BUFS)-1:0]     rd_buf_idx,
  output logic [1:0]                      state_dbg
);

  localparam int unsigned IDX_W = $clog2(NUM_BUFS);
  localparam int unsigned FR_W  = $clog2(NUM_BUFS + 1);
  localparam int unsigned BC_W  = (BURSTS_PER_FRAME > 1) ? $clog2(BURSTS_PER_FRAME) : 1;

  localparam logic [FR_W-1:0]  FR_FULL  = FR_W'(NUM_BUFS);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BURSTS_PER_FRAME - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BUFS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               write_en_q, write_en_d;
  logic               read_en_q, read_en_d;
  logic               wr_frame_done_q, wr_frame_done_d;
  logic               rd_frame_done_q, rd_frame_done_d;
  logic               rd_underrun_q, rd_underrun_d;
  logic [FR_W-1:0]    frames_ready_q, frames_ready_d;
  logic [IDX_W-1:0]   wr_buf_idx_q, wr_buf_idx_d;
  logic [IDX_W-1:0]   rd_buf_idx_q, rd_buf_idx_d;
  logic [BC_W-1:0]    wr_burst_cnt_q, wr_burst_cnt_d;
  logic [BC_W-1:0]    rd_burst_cnt_q, rd_burst_cnt_d;

  // Address depends only on registered counters, never on the request inputs.
  function automatic logic [ADDR_W-1:0] burst_addr(input logic [IDX_W-1:0] idx,
                                                   input logic [BC_W-1:0]  cnt);
    return ADDR_W'(BASE_ADDR)
         + ADDR_W'(idx) * ADDR_W'(FRAME_STRIDE)
         + ADDR_W'(cnt) * ADDR_W'(BURST_LEN);
  endfunction

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    write_en_d      = write_en_q;
    read_en_d       = read_en_q;
    wr_frame_done_d = 1'b0;
    rd_frame_done_d = 1'b0;
    rd_underrun_d   = 1'b0;
    frames_ready_d  = frames_ready_q;
    wr_buf_idx_d    = wr_buf_idx_q;
    rd_buf_idx_d    = rd_buf_idx_q;
    wr_burst_cnt_d  = wr_burst_cnt_q;
    rd_burst_cnt_d  = rd_burst_cnt_q;

    case (state_q)
      ST_IDLE: begin
        rd_underrun_d = vga_rd_req && (frames_ready_q == '0);
        if (vga_rd_req && (frames_ready_q != '0)) begin
          state_d   = ST_READ;
          read_en_d = 1'b1;
          addr_d    = burst_addr(rd_buf_idx_q, rd_burst_cnt_q);
        end else if (image_wr_req && (frames_ready_q != FR_FULL)) begin
          state_d    = ST_WRITE;
          write_en_d = 1'b1;
          addr_d     = burst_addr(wr_buf_idx_q, wr_burst_cnt_q);
        end
      end

      ST_WRITE: begin
        if (write_ack) begin
          state_d    = ST_IDLE;
          write_en_d = 1'b0;
          if (wr_burst_cnt_q == BC_LAST) begin
            wr_burst_cnt_d  = '0;
            wr_buf_idx_d    = (wr_buf_idx_q == IDX_LAST) ? '0 : wr_buf_idx_q + 1'b1;
            frames_ready_d  = frames_ready_q + 1'b1;
            wr_frame_done_d = 1'b1;
          end else begin
            wr_burst_cnt_d = wr_burst_cnt_q + 1'b1;
          end
        end
      end

      ST_READ: begin
        if (read_ack) begin
          state_d   = ST_IDLE;
          read_en_d = 1'b0;
          if (rd_burst_cnt_q == BC_LAST) begin
            rd_burst_cnt_d  = '0;
            rd_buf_idx_d    = (rd_buf_idx_q == IDX_LAST) ? '0 : rd_buf_idx_q + 1'b1;
            frames_ready_d  = frames_ready_q - 1'b1;
            rd_frame_done_d = 1'b1;
          end else begin
            rd_burst_cnt_d = rd_burst_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d    = ST_IDLE;
        write_en_d = 1'b0;
        read_en_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge S_CLK) begin
    if (RST) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      write_en_q      <= 1'b0;
      read_en_q       <= 1'b0;
      wr_frame_done_q <= 1'b0;
      rd_frame_done_q <= 1'b0;
      rd_underrun_q   <= 1'b0;
      frames_ready_q  <= '0;
      wr_buf_idx_q    <= '0;
      rd_buf_idx_q    <= '0;
      wr_burst_cnt_q  <= '0;
      rd_burst_cnt_q  <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      write_en_q      <= write_en_d;
      read_en_q       <= read_en_d;
      wr_frame_done_q <= wr_frame_done_d;
      rd_frame_done_q <= rd_frame_done_d;
      rd_underrun_q   <= rd_underrun_d;
      frames_ready_q  <= frames_ready_d;
      wr_buf_idx_q    <= wr_buf_idx_d;
      rd_buf_idx_q    <= rd_buf_idx_d;
      wr_burst_cnt_q  <= wr_burst_cnt_d;
      rd_burst_cnt_q  <= rd_burst_cnt_d;
    end
  end

  assign addr          = addr_q;
  assign write_en      = write_en_q;
  assign read_en       = read_en_q;
  assign wr_frame_done = wr_frame_done_q;
  assign rd_frame_done = rd_frame_done_q;
  assign rd_underrun   = rd_underrun_q;
  assign frames_ready  = frames_ready_q;
  assign wr_buf_idx    = wr_buf_idx_q;
  assign rd_buf_idx    = rd_buf_idx_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Directed bench for sdram_frame_arbiter: two 4-burst frame buffers at 0x100
// and 0x120, with the burst engine modelled as an ack three cycles after grant.
module tb_sdram_frame_arbiter;

  localparam int ADDR_W = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              image_wr_req = 1'b0;
  logic              vga_rd_req = 1'b0;
  logic              write_ack = 1'b0;
  logic              read_ack = 1'b0;
  logic [ADDR_W-1:0] addr;
  logic              write_en, read_en;
  logic              wr_frame_done, rd_frame_done, rd_underrun;
  logic [1:0]        frames_ready;
  logic [0:0]        wr_buf_idx, rd_buf_idx;
  logic [1:0]        state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [ADDR_W-1:0] exp_q[$];

  sdram_frame_arbiter #(
    .ADDR_W(ADDR_W), .BASE_ADDR(32'h100), .BURST_LEN(8),
    .BURSTS_PER_FRAME(4), .FRAME_STRIDE(32), .NUM_BUFS(2)
  ) dut (
    .S_CLK(clk), .RST(rst),
    .image_wr_req(image_wr_req), .vga_rd_req(vga_rd_req),
    .write_ack(write_ack), .read_ack(read_ack),
    .addr(addr), .write_en(write_en), .read_en(read_en),
    .wr_frame_done(wr_frame_done), .rd_frame_done(rd_frame_done),
    .rd_underrun(rd_underrun), .frames_ready(frames_ready),
    .wr_buf_idx(wr_buf_idx), .rd_buf_idx(rd_buf_idx), .state_dbg(state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: wait (bounded) for a write grant, ack it 3 cycles after the rise,
  // then report the frame-done pulse and enable seen in the following cycle.
  task automatic serve_write(output bit ok, output logic [ADDR_W-1:0] a,
                             output bit done, output bit en_after);
    ok = 1'b0; a = '0; done = 1'b0; en_after = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (write_en === 1'b1) begin ok = 1'b1; a = addr; end
    end
    if (ok) begin
      repeat (2) @(negedge clk);
      write_ack = 1'b1;
      @(negedge clk);
      done = wr_frame_done;
      en_after = write_en;
      write_ack = 1'b0;
    end
  endtask

  task automatic serve_read(output bit ok, output logic [ADDR_W-1:0] a,
                            output bit done, output bit en_after);
    ok = 1'b0; a = '0; done = 1'b0; en_after = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (read_en === 1'b1) begin ok = 1'b1; a = addr; end
    end
    if (ok) begin
      repeat (2) @(negedge clk);
      read_ack = 1'b1;
      @(negedge clk);
      done = rd_frame_done;
      en_after = read_en;
      read_ack = 1'b0;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; image_wr_req = 1'b0; vga_rd_req = 1'b0;
    write_ack = 1'b0; read_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({write_en, read_en, wr_frame_done, rd_frame_done, rd_underrun} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000",
               {write_en, read_en, wr_frame_done, rd_frame_done, rd_underrun});
    end
    n_checks++;
    if (addr !== 20'h0) begin
      n_fail++; $display("FAIL reset_addr: got %h expected 00000", addr);
    end
    n_checks++;
    if ({frames_ready, wr_buf_idx, rd_buf_idx, state_dbg} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_counts: got fr=%0d wi=%0d ri=%0d st=%0d expected all 0",
               frames_ready, wr_buf_idx, rd_buf_idx, state_dbg);
    end
    rst = 1'b0;
  endtask

  task automatic test_write_frame();
    bit ok, done, en_after;
    logic [ADDR_W-1:0] a, e;
    logic [3:0] done_v;
    done_v = '0;
    for (int i = 0; i < 4; i++) exp_q.push_back(ADDR_W'(32'h100 + 8 * i));
    image_wr_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      serve_write(ok, a, done, en_after);
      if (i == 3) image_wr_req = 1'b0;
      e = exp_q.pop_front();
      done_v[i] = done;
      n_checks++;
      if (!ok || a !== e) begin
        n_fail++; $display("FAIL wr_addr[%0d]: got %h (granted=%0d) expected %h", i, a, ok, e);
      end
      n_checks++;
      if (en_after !== 1'b0) begin
        n_fail++; $display("FAIL wr_en_drop[%0d]: got %b expected 0", i, en_after);
      end
    end
    n_checks++;
    if (done_v !== 4'b1000) begin
      n_fail++; $display("FAIL wr_frame_done: got %b expected 1000", done_v);
    end
    n_checks++;
    if (frames_ready !== 2'd1 || wr_buf_idx !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_frame_state: got fr=%0d wi=%0d expected fr=1 wi=1", frames_ready, wr_buf_idx);
    end
  endtask

  task automatic test_read_frame();
    bit ok, done, en_after, saw_en;
    logic [ADDR_W-1:0] a, e;
    logic [3:0] done_v;
    done_v = '0;
    for (int i = 0; i < 4; i++) exp_q.push_back(ADDR_W'(32'h100 + 8 * i));
    vga_rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      serve_read(ok, a, done, en_after);
      if (i == 3) vga_rd_req = 1'b0;
      e = exp_q.pop_front();
      done_v[i] = done;
      n_checks++;
      if (!ok || a !== e || en_after !== 1'b0) begin
        n_fail++;
        $display("FAIL rd_addr[%0d]: got %h (granted=%0d en_after=%0d) expected %h en_after=0",
                 i, a, ok, en_after, e);
      end
    end
    n_checks++;
    if (done_v !== 4'b1000) begin
      n_fail++; $display("FAIL rd_frame_done: got %b expected 1000", done_v);
    end
    n_checks++;
    if (frames_ready !== 2'd0 || rd_buf_idx !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_frame_state: got fr=%0d ri=%0d expected fr=0 ri=1", frames_ready, rd_buf_idx);
    end
    @(negedge clk);
    vga_rd_req = 1'b1;
    @(negedge clk);
    vga_rd_req = 1'b0;
    n_checks++;
    if (rd_underrun !== 1'b1 || read_en !== 1'b0) begin
      n_fail++;
      $display("FAIL underrun: got underrun=%b read_en=%b expected 1 0", rd_underrun, read_en);
    end
    saw_en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (read_en !== 1'b0 || rd_underrun !== 1'b0) saw_en = 1'b1;
    end
    n_checks++;
    if (saw_en !== 1'b0) begin
      n_fail++; $display("FAIL underrun_after: got activity=1 expected 0");
    end
  endtask

  task automatic test_full();
    bit ok, done, en_after, saw_en;
    logic [ADDR_W-1:0] a, e;
    apply_reset();
    for (int i = 0; i < 8; i++) exp_q.push_back(ADDR_W'(32'h100 + 8 * i));
    image_wr_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      serve_write(ok, a, done, en_after);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok || a !== e) begin
        n_fail++; $display("FAIL full_wr_addr[%0d]: got %h (granted=%0d) expected %h", i, a, ok, e);
      end
    end
    n_checks++;
    if (frames_ready !== 2'd2 || wr_buf_idx !== 1'b0) begin
      n_fail++;
      $display("FAIL full_state: got fr=%0d wi=%0d expected fr=2 wi=0", frames_ready, wr_buf_idx);
    end
    saw_en = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (write_en !== 1'b0) saw_en = 1'b1;
    end
    n_checks++;
    if (saw_en !== 1'b0) begin
      n_fail++; $display("FAIL full_stall: got write_en=1 expected no grant while full");
    end
    vga_rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      serve_read(ok, a, done, en_after);
      if (i == 3) vga_rd_req = 1'b0;
      n_checks++;
      if (!ok || a !== ADDR_W'(32'h100 + 8 * i)) begin
        n_fail++;
        $display("FAIL full_rd_addr[%0d]: got %h (granted=%0d) expected %h",
                 i, a, ok, ADDR_W'(32'h100 + 8 * i));
      end
    end
    n_checks++;
    if (frames_ready !== 2'd1) begin
      n_fail++; $display("FAIL full_after_read: got fr=%0d expected 1", frames_ready);
    end
    serve_write(ok, a, done, en_after);
    image_wr_req = 1'b0;
    n_checks++;
    if (!ok || a !== 20'h100) begin
      n_fail++; $display("FAIL full_resume_wrap: got %h (granted=%0d) expected 00100", a, ok);
    end
  endtask

  task automatic test_priority();
    bit ok, done, en_after;
    logic [ADDR_W-1:0] a;
    logic [3:0] rd_done_v, wr_done_v;
    rd_done_v = '0; wr_done_v = '0;
    apply_reset();
    image_wr_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      serve_write(ok, a, done, en_after);
      if (i == 3) image_wr_req = 1'b0;
    end
    n_checks++;
    if (frames_ready !== 2'd1) begin
      n_fail++; $display("FAIL prio_setup: got fr=%0d expected 1", frames_ready);
    end
    @(negedge clk);
    image_wr_req = 1'b1;
    vga_rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      serve_read(ok, a, done, en_after);
      vga_rd_req = 1'b0;
      rd_done_v[i] = done;
      n_checks++;
      if (!ok || a !== ADDR_W'(32'h100 + 8 * i)) begin
        n_fail++;
        $display("FAIL prio_rd[%0d]: got %h (granted=%0d) expected %h",
                 i, a, ok, ADDR_W'(32'h100 + 8 * i));
      end
      serve_write(ok, a, done, en_after);
      wr_done_v[i] = done;
      if (i < 3) vga_rd_req = 1'b1;
      else image_wr_req = 1'b0;
      n_checks++;
      if (!ok || a !== ADDR_W'(32'h120 + 8 * i)) begin
        n_fail++;
        $display("FAIL prio_wr[%0d]: got %h (granted=%0d) expected %h",
                 i, a, ok, ADDR_W'(32'h120 + 8 * i));
      end
    end
    n_checks++;
    if (rd_done_v !== 4'b1000 || wr_done_v !== 4'b1000) begin
      n_fail++;
      $display("FAIL prio_done: got rd=%b wr=%b expected 1000 1000", rd_done_v, wr_done_v);
    end
    n_checks++;
    if (frames_ready !== 2'd1 || wr_buf_idx !== 1'b0 || rd_buf_idx !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_state: got fr=%0d wi=%0d ri=%0d expected 1 0 1",
               frames_ready, wr_buf_idx, rd_buf_idx);
    end
  endtask

  task automatic test_stray_ack();
    bit ok, done, en_after;
    logic [ADDR_W-1:0] a;
    ok = 1'b0;
    image_wr_req = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (write_en === 1'b1) ok = 1'b1;
    end
    read_ack = 1'b1;
    @(negedge clk);
    read_ack = 1'b0;
    n_checks++;
    if (!ok || write_en !== 1'b1 || addr !== 20'h100 || frames_ready !== 2'd1 ||
        rd_frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_rd_ack: got en=%b addr=%h fr=%0d rdd=%b expected 1 00100 1 0",
               write_en, addr, frames_ready, rd_frame_done);
    end
    write_ack = 1'b1;
    @(negedge clk);
    write_ack = 1'b0;
    image_wr_req = 1'b0;
    n_checks++;
    if (write_en !== 1'b0 || frames_ready !== 2'd1) begin
      n_fail++;
      $display("FAIL stray_wr_end: got en=%b fr=%0d expected 0 1", write_en, frames_ready);
    end
    vga_rd_req = 1'b1;
    serve_read(ok, a, done, en_after);
    vga_rd_req = 1'b0;
    n_checks++;
    if (!ok || a !== 20'h120) begin
      n_fail++; $display("FAIL stray_rd_cnt: got %h (granted=%0d) expected 00120", a, ok);
    end
    @(negedge clk);
    write_ack = 1'b1;
    @(negedge clk);
    write_ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if (write_en !== 1'b0 || state_dbg !== 2'd0 || frames_ready !== 2'd1 ||
        wr_frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_idle_ack: got en=%b st=%0d fr=%0d wfd=%b expected 0 0 1 0",
               write_en, state_dbg, frames_ready, wr_frame_done);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok, done, en_after;
    logic [ADDR_W-1:0] a;
    ok = 1'b0;
    image_wr_req = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (write_en === 1'b1) ok = 1'b1;
    end
    n_checks++;
    if (!ok || addr !== 20'h108) begin
      n_fail++; $display("FAIL mid_pre_addr: got %h (granted=%0d) expected 00108", addr, ok);
    end
    rst = 1'b1;
    image_wr_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({write_en, read_en, wr_frame_done, rd_frame_done, rd_underrun} !== 5'b0 ||
        addr !== 20'h0 || {frames_ready, wr_buf_idx, rd_buf_idx, state_dbg} !== 6'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got en=%b addr=%h fr=%0d wi=%0d ri=%0d st=%0d expected all 0",
               write_en, addr, frames_ready, wr_buf_idx, rd_buf_idx, state_dbg);
    end
    rst = 1'b0;
    write_ack = 1'b1;
    @(negedge clk);
    write_ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if (write_en !== 1'b0 || frames_ready !== 2'd0 || wr_buf_idx !== 1'b0 ||
        wr_frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_stray_ack: got en=%b fr=%0d wi=%0d wfd=%b expected 0 0 0 0",
               write_en, frames_ready, wr_buf_idx, wr_frame_done);
    end
    image_wr_req = 1'b1;
    serve_write(ok, a, done, en_after);
    image_wr_req = 1'b0;
    n_checks++;
    if (!ok || a !== 20'h100) begin
      n_fail++; $display("FAIL mid_restart: got %h (granted=%0d) expected 00100", a, ok);
    end
  endtask

  initial begin
    test_reset();
    test_write_frame();
    test_read_frame();
    test_full();
    test_priority();
    test_stray_ack();
    test_reset_mid_burst();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
